// File: rtl/vga_sync_gen_if.sv
// Bundle of VGA timing signals between the sync generator and its neighbours:
// the divider's pixel clock in, position/sync/blanking out to the renderer.
interface vga_sync_gen_if;
  logic       pix_clk;
  logic       pixel_tick;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [9:0] x;
  logic [9:0] y;
  logic       frame_start;

  modport master (
    input  pix_clk,
    output pixel_tick, hsync, vsync, video_on, x, y, frame_start
  );

  modport slave (
    output pix_clk,
    input  pixel_tick, hsync, vsync, video_on, x, y, frame_start
  );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA timing generator: edge-detects the pixel clock into a one-clk tick and
// walks x/y position counters, producing registered sync, blanking and frame start.
module vga_sync_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input logic            clk,
  input logic            reset,
  vga_sync_gen_if.master vga
);
  localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_DISPLAY + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_DISPLAY + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [9:0] X_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_VISIBLE  = 10'(H_DISPLAY);
  localparam logic [9:0] Y_VISIBLE  = 10'(V_DISPLAY);
  localparam logic [9:0] X_HS_START = 10'(HS_START);
  localparam logic [9:0] X_HS_END   = 10'(HS_END);
  localparam logic [9:0] Y_VS_START = 10'(VS_START);
  localparam logic [9:0] Y_VS_END   = 10'(VS_END);

  // Reset parks the counters on the last position, so the decoded outputs
  // must match that position rather than a blanket "inactive" value.
  localparam bit HS_RST = ((H_TOTAL - 1) >= HS_START && (H_TOTAL - 1) < HS_END) ? SYNC_POL : !SYNC_POL;
  localparam bit VS_RST = ((V_TOTAL - 1) >= VS_START && (V_TOTAL - 1) < VS_END) ? SYNC_POL : !SYNC_POL;
  localparam bit VO_RST = ((H_TOTAL - 1) < H_DISPLAY) && ((V_TOTAL - 1) < V_DISPLAY);

  logic       pix_q;
  logic       tick_q;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_on_q, video_on_d;
  logic       frame_start_q, frame_start_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (tick_q) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
    // Decode from the next position so outputs change on the same edge as x/y.
    hsync_d       = (x_d >= X_HS_START && x_d < X_HS_END) ? SYNC_POL : !SYNC_POL;
    vsync_d       = (y_d >= Y_VS_START && y_d < Y_VS_END) ? SYNC_POL : !SYNC_POL;
    video_on_d    = (x_d < X_VISIBLE) && (y_d < Y_VISIBLE);
    frame_start_d = tick_q && (x_q == X_LAST) && (y_q == Y_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_q         <= 1'b0;
      tick_q        <= 1'b0;
      x_q           <= X_LAST;
      y_q           <= Y_LAST;
      hsync_q       <= HS_RST;
      vsync_q       <= VS_RST;
      video_on_q    <= VO_RST;
      frame_start_q <= 1'b0;
    end else begin
      pix_q         <= vga.pix_clk;
      tick_q        <= vga.pix_clk & ~pix_q;
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.pixel_tick  = tick_q;
  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.video_on    = video_on_q;
  assign vga.frame_start = frame_start_q;
endmodule
